// File: rtl/motor_ramp_pkg.sv
// Shared types and helpers for the motor ramp command stage.
// Holds the state encoding, the speed type and the speed/period conversions.
package motor_ramp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    DWELL,
    ESTOP
  } state_t;

  typedef logic signed [8:0] speed_t;

  localparam logic [7:0] MIN_PERIOD = 8'd2;

  // Magnitude of a signed speed; -256 folds onto 255 so it fits the duty range.
  function automatic logic [7:0] speed_mag(input speed_t s);
    logic [8:0] neg;
    neg = ~s + 9'd1;
    if (!s[8]) begin
      return s[7:0];
    end else if (s == 9'h100) begin
      return 8'hFF;
    end else begin
      return neg[7:0];
    end
  endfunction

  function automatic logic [7:0] clamp_period(input logic [7:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  // Duty can never exceed the PWM period, so the usable target is the smaller of the two.
  function automatic logic [7:0] eff_target(input logic [7:0] mag, input logic [7:0] per);
    return (mag < per) ? mag : per;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle ramp tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_50,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Speed command stage for the PWM motor controller: slews duty toward a signed
// target at a fixed rate, reverses only through zero plus a braked dwell.
module motor_ramp_ctrl
  import motor_ramp_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned STEP           = 1,
  parameter int unsigned DWELL_TICKS    = 20,
  parameter int unsigned DEFAULT_PERIOD = 100
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  speed_t     cmd_speed,
  input  logic [7:0] cmd_period,
  input  logic       estop,
  output logic [7:0] dutyCycle,
  output logic [7:0] period,
  output logic       direction,
  output logic       brake,
  output logic       pwmOutEnable,
  output logic       busy,
  output logic       at_target
);

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam int unsigned DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);
  localparam logic [7:0] PERIOD_RST = 8'(DEFAULT_PERIOD);

  state_t          state, state_n;
  logic [7:0]      mag_t, mag_t_n;
  logic            dir_t, dir_t_n;
  logic [DW_W-1:0] dwell_cnt, dwell_n;
  logic [7:0]      duty_n, period_n;
  logic            direction_n, brake_n, enable_n, busy_n, at_target_n;
  logic [7:0]      mag_e_n, cmd_mag, toward, down;
  logic            tick, accept;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_50 (clk_50),
    .reset  (reset),
    .tick   (tick)
  );

  function automatic logic [7:0] step_toward(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] d9, t9, s9;
    d9 = {1'b0, d};
    t9 = {1'b0, t};
    s9 = d9;
    if (d9 < t9) begin
      s9 = d9 + STEP9;
      if (s9 > t9) s9 = t9;
    end else if (d9 > t9) begin
      s9 = (d9 - t9 > STEP9) ? d9 - STEP9 : t9;
    end
    return s9[7:0];
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] d);
    logic [8:0] d9, s9;
    d9 = {1'b0, d};
    s9 = (d9 > STEP9) ? d9 - STEP9 : 9'd0;
    return s9[7:0];
  endfunction

  assign cmd_ready = (state != ESTOP) && !estop;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    mag_t_n     = mag_t;
    dir_t_n     = dir_t;
    period_n    = period;
    state_n     = state;
    duty_n      = dutyCycle;
    direction_n = direction;
    brake_n     = brake;
    enable_n    = pwmOutEnable;
    dwell_n     = dwell_cnt;
    cmd_mag     = speed_mag(cmd_speed);

    // A zero command carries no sign, so it keeps the present direction and
    // never triggers a reversal dwell just to stop.
    if (accept) begin
      mag_t_n  = cmd_mag;
      dir_t_n  = (cmd_mag == 8'd0) ? direction : !cmd_speed[8];
      period_n = clamp_period(cmd_period);
    end
    mag_e_n = eff_target(mag_t_n, period_n);
    toward  = step_toward(dutyCycle, mag_e_n);
    down    = step_down(dutyCycle);

    if (estop) begin
      state_n  = ESTOP;
      duty_n   = '0;
      brake_n  = 1'b1;
      enable_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          duty_n   = '0;
          brake_n  = 1'b0;
          enable_n = 1'b0;
          if (accept && mag_e_n != 8'd0) begin
            direction_n = dir_t_n;
            enable_n    = 1'b1;
            state_n     = RAMP;
          end
        end
        RAMP: begin
          if (tick) begin
            if (dir_t_n != direction) begin
              if (dutyCycle != 8'd0) begin
                duty_n = down;
              end else begin
                state_n = DWELL;
                brake_n = 1'b1;
                dwell_n = '0;
              end
            end else begin
              duty_n = toward;
              if (toward == mag_e_n) begin
                if (mag_e_n == 8'd0) begin
                  state_n  = IDLE;
                  enable_n = 1'b0;
                end else begin
                  state_n = HOLD;
                end
              end
            end
          end
        end
        HOLD: begin
          if (accept && (mag_e_n != dutyCycle || dir_t_n != direction)) begin
            state_n = RAMP;
          end
        end
        DWELL: begin
          duty_n   = '0;
          brake_n  = 1'b1;
          enable_n = 1'b1;
          if (tick) begin
            if (dwell_cnt == DWELL_LAST) begin
              brake_n     = 1'b0;
              direction_n = dir_t_n;
              state_n     = RAMP;
            end else begin
              dwell_n = dwell_cnt + 1'b1;
            end
          end
        end
        ESTOP: begin
          state_n     = IDLE;
          mag_t_n     = '0;
          dir_t_n     = 1'b0;
          direction_n = 1'b0;
          duty_n      = '0;
          brake_n     = 1'b0;
          enable_n    = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n      = (state_n == RAMP) || (state_n == DWELL);
    at_target_n = (duty_n == eff_target(mag_t_n, period_n)) && (direction_n == dir_t_n);
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mag_t        <= '0;
      dir_t        <= 1'b0;
      dwell_cnt    <= '0;
      dutyCycle    <= '0;
      period       <= PERIOD_RST;
      direction    <= 1'b0;
      brake        <= 1'b0;
      pwmOutEnable <= 1'b0;
      busy         <= 1'b0;
      at_target    <= 1'b1;
    end else begin
      state        <= state_n;
      mag_t        <= mag_t_n;
      dir_t        <= dir_t_n;
      dwell_cnt    <= dwell_n;
      dutyCycle    <= duty_n;
      period       <= period_n;
      direction    <= direction_n;
      brake        <= brake_n;
      pwmOutEnable <= enable_n;
      busy         <= busy_n;
      at_target    <= at_target_n;
    end
  end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Command stage directly upstream of the PWM motor controller; drives its dutyCycle, period, direction, brake and pwmOutEnable inputs.
- Accepts signed speed commands over a valid/ready handshake and slews the duty cycle toward the target at a fixed rate.
- Reverses direction only via ramp-down to 0, a braked dwell, then ramp-up.
- Emergency stop overrides everything.

Parameters:
- TICK_DIV, 50000, clk_50 cycles per ramp tick (1 ms at 50 MHz); minimum 2.
- STEP, 1, duty increment/decrement per tick; 1..255.
- DWELL_TICKS, 20, ticks spent braked at zero duty before a direction reversal; minimum 1.
- DEFAULT_PERIOD, 100, period output after reset; minimum 2.

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the clk_50 rising edge
- cmd_speed  in  9  signed two's complement target; sign gives direction (negative → direction 0), magnitude gives duty; −256 is treated as −255
- cmd_period  in  8  PWM period to apply; values 0 and 1 are clamped to 2
- estop  in  1  emergency stop, level sensitive, synchronous to clk_50
- dutyCycle  out  8  to pwmc
- period  out  8  to pwmc
- direction  out  1  to pwmc; 1 = clockwise
- brake  out  1  to pwmc
- pwmOutEnable  out  1  to pwmc
- busy  out  1  high in RAMP and DWELL
- at_target  out  1  high when duty equals effective target and direction equals target direction

Behaviour:
- Reset values (async, immediate):
  - dutyCycle 0, direction 0, brake 0, pwmOutEnable 0
  - period DEFAULT_PERIOD, busy 0, at_target 1
  - state IDLE, target 0, tick counter 0
- All outputs are registered except cmd_ready.
- cmd_ready = (state != ESTOP) && !estop (combinational).
- Tick: free-running counter 0..TICK_DIV-1. It pulses for one cycle at TICK_DIV-1, then wraps. It is cleared only by reset and is never restarted by commands.
- On accept (edge N):
  - Latch target magnitude mag_t and sign dir_t.
  - period <= clamped cmd_period at edge N.
  - Effective target mag_e = min(mag_t, period).
  - State change is visible after edge N; duty first moves on the next tick.
  - A new command may be accepted in any non-ESTOP state and retargets immediately.
- Duty arithmetic: 9-bit intermediate. Steps saturate exactly at mag_e and at 0, with no overshoot and no wrap.
- States and transitions:
  - IDLE: duty 0, enable 0, brake 0.
    - Accept with mag_e != 0 → direction <= dir_t, enable <= 1, go to RAMP.
    - Accept with mag_e == 0 → stay in IDLE.
  - RAMP: enable 1, brake 0. Per tick:
    - If dir_t != direction and duty > 0: duty -= STEP, saturating at 0.
    - If dir_t != direction and duty == 0: go to DWELL.
    - Otherwise: duty moves toward mag_e by STEP.
    - After the update: duty == mag_e == 0 → IDLE with enable 0; duty == mag_e != 0 → HOLD.
  - HOLD: duty constant.
    - Accept changing mag_e or dir_t → RAMP.
    - Accept of an identical command → stay in HOLD.
    - A period change lowering mag_e below duty → RAMP.
  - DWELL: duty 0, brake 1, enable 1. Counts DWELL_TICKS ticks, then: brake 0, direction <= dir_t, go to RAMP.
    - If a retarget during DWELL restores the original direction, the dwell still completes.
  - ESTOP: entered on the edge after estop is seen high, from any state. Outputs: duty 0, brake 1, enable 1.
    - Stays while estop is high.
    - On estop low: target cleared to 0, brake 0, enable 0, go to IDLE.
    - Commands presented during ESTOP are not accepted.
- Simultaneous estop and cmd_valid: no accept (cmd_ready is low); ESTOP is entered.
- Reset mid-operation: all state and outputs return to reset values immediately; no dwell is required.

Decomposition:
- motor_ramp_pkg contains:
  - state enum (IDLE, RAMP, HOLD, DWELL, ESTOP)
  - speed_t (signed [8:0])
  - MIN_PERIOD = 2
  - magnitude/clamp function
- Sub-module tick_gen (TICK_DIV parameter; ports clk_50, reset, tick) contains the prescaler.

Test Plan (TICK_DIV=4, STEP=10, DWELL_TICKS=3):
- Reset, then cmd_speed=+50, cmd_period=100 → direction 1, enable 1; duty 10, 20, 30, 40, 50 on successive ticks; then HOLD, at_target 1, busy 0.
- From HOLD +50, command −30 → duty 40..0, then brake 1 for 3 ticks, then direction 0 and duty 10, 20, 30; duty is never non-zero while direction differs from the old sign.
- cmd_speed=+200, cmd_period=120 → duty saturates at 120; cmd_period=1 → period 2.
- At +45 with STEP=10 → duty 10, 20, 30, 40, 45 with no overshoot; command 0 → duty 35..5, 0, then IDLE with enable 0.
- estop asserted during RAMP with a simultaneous cmd_valid → cmd_ready 0; next edge duty 0, brake 1, enable 1; estop released → IDLE with all outputs 0.
- Reset asserted mid-DWELL → all outputs take reset values asynchronously; at_target 1.
